nat_tuple_client: RTL and testbench
===================================

// Module: nat_tuple_client
// PURPOSE
//  Requesting end of the 128-bit tuple / 16-bit connection-index lookup interface of the NAT hash block.
//  Accepts one parsed L3/L4 header at a time and packs it into a lookup tuple.
//  Holds the request until the hash table answers, then emits the header with NAT translation applied.
//  One instance per direction: DIR=0 on the LAN->WAN lookup channel, DIR=1 on the WAN->LAN channel.
// PARAMETERS
//  DIR        0            0: outbound (rewrite source), 1: inbound (rewrite destination)
//  HASH_LEN   6            connection-index width; valid conn ids are 0..2^HASH_LEN-1
//  PUBLIC_IP  32'hC0A80001 NAT public address, written as src_ip on outbound
//  LAN_IP     32'h0A000002 inner host address, used in inbound tuple and as rewritten dst_ip
//  PORT_BASE  16'd40000    public port = PORT_BASE + conn id
//  TIMEOUT    16'd256      cycles to wait for conn_valid before abandoning the request
// PORTS
//  clk            in   1    clock
//  rst_n          in   1    asynchronous active-low reset
//  hdr_valid      in   1    header offer
//  hdr_ready      out  1    header accepted when hdr_valid&hdr_ready
//  hdr_src_ip     in   32   |
//  hdr_dst_ip     in   32   |  parsed header fields
//  hdr_src_port   in   16   |
//  hdr_dst_port   in   16   |
//  hdr_proto      in   8    |
//  tuple_data     out  128  lookup tuple to hash block
//  tuple_valid    out  1    lookup request
//  conn_data      in   16   hash response (conn id on DIR=0, inner port on DIR=1)
//  conn_valid     in   1    single-cycle response strobe
//  out_valid      out  1    translated header valid
//  out_ready      in   1    downstream accept
//  out_src_ip, out_dst_ip (32), out_src_port, out_dst_port (16), out_proto (8)  out  translated header
//  out_err        out  1    1: header must be discarded (timeout / port out of range)
//  timeout_cnt    out  16   saturating count of timeouts
//  stray_cnt      out  16   saturating count of conn_valid seen outside REQ
// BEHAVIOUR
//  Reset: state=IDLE; hdr_ready=1; tuple_valid=0; tuple_data=0; out_valid=0; out_err=0.
//  Reset also zeroes all out_* fields and both counters. Reset mid-request abandons it silently.
//  FSM IDLE -> REQ -> EMIT -> IDLE:
//  - IDLE: hdr_ready=1; on handshake latch the header, build tuple_data, load wait counter with TIMEOUT.
//    Go to REQ; on DIR=1 with a port out of range, go to EMIT with out_err=1 instead.
//  - REQ: hdr_ready=0; the wait counter decrements every cycle.
//  - EMIT: out_valid=1 and fields stay stable until out_ready; then go to IDLE.
//  Exits from REQ:
//  - conn_valid=1: latch conn_data[15:0], go to EMIT with out_err=0.
//  - counter reaches 0 with no conn_valid: go to EMIT with out_err=1 and increment timeout_cnt.
//  - conn_valid and expiry in the same cycle: conn_valid wins.
//  tuple_valid = req_q & ~conn_valid (combinational gate).
//  The hash block therefore never samples a second request in the cycle after it responds.
//  tuple_data[127:104]=0. Field packing by DIR:
//  - DIR=0: [103:72]=src_ip [71:40]=dst_ip [39:24]=src_port [23:8]=dst_port [7:0]=proto.
//  - DIR=1: [103:72]=src_ip [71:40]=LAN_IP [39:24]=src_port [23:8]=dst_port-PORT_BASE [7:0]=proto.
//  DIR=1 port range: dst_port<PORT_BASE or dst_port-PORT_BASE>=2^HASH_LEN is out of range.
//    Such a header is never sent to the hash block.
//  Translation:
//  - DIR=0: out_src_ip=PUBLIC_IP; out_src_port=PORT_BASE+conn_data[HASH_LEN-1:0] (16-bit, wraps mod 2^16).
//  - DIR=1: out_dst_ip=LAN_IP; out_dst_port=conn_data.
//  - All other fields pass through. On out_err the fields pass through untranslated.
//  Latency: accept at edge 0; first tuple_valid cycle is cycle 1; out_valid the cycle after conn_valid.
//  Sustained throughput: one header per (lookup latency + 2) cycles.
//  Late conn_valid (IDLE or EMIT) is ignored apart from stray_cnt; it never alters out_*.
//  Both counters saturate at 16'hFFFF.
// STRUCTURE
//  Shared package nat_pkg holds:
//  - tuple field offsets (PROTO_LSB=0, PORTA_LSB=8, PORTB_LSB=24, IPA_LSB=40, IPB_LSB=72);
//  - TUPLE_W=128 and CONN_W=16;
//  - the FSM state enum {IDLE, REQ, EMIT}.
//  Single module; the tuple packer is a function in nat_pkg. No sub-module is warranted.
// TESTING
//  1. DIR=0, header 10.0.0.2:1234 -> 8.8.8.8:53 UDP(17), conn_valid 5 cycles later with 3
//     -> tuple[103:72]=0A000002, [7:0]=11; out src 192.168.0.1:40003, dst unchanged, out_err=0.
//  2. conn_valid in the first REQ cycle -> tuple_valid low in that same cycle; never high again
//     for this header; out_valid on the next cycle.
//  3. No conn_valid for 256 cycles -> out_err=1, timeout_cnt=1.
//     conn_valid at cycle 260 -> stray_cnt=1 and out_* unchanged.
//  4. DIR=1, dst_port 40007 -> tuple[23:8]=7, [71:40]=LAN_IP; conn_data=1234
//     -> out dst 10.0.0.2:1234. dst_port 39999 or 40064 -> out_err=1 with tuple_valid never asserted.
//  5. out_ready held low 10 cycles in EMIT -> out fields stable, hdr_ready=0;
//     back-to-back headers are each accepted only after the previous out handshake.
//  6. rst_n pulsed low during REQ -> all outputs reset asynchronously; next header proceeds normally.

Source files
------------

// File: rtl/nat_pkg.sv
// Shared definitions for the NAT lookup clients: tuple layout, widths, FSM states
// and the tuple packer used by both lookup directions.
package nat_pkg;

  localparam int TUPLE_W   = 128;
  localparam int CONN_W    = 16;

  localparam int PROTO_LSB = 0;
  localparam int PORTA_LSB = 8;
  localparam int PORTB_LSB = 24;
  localparam int IPA_LSB   = 40;
  localparam int IPB_LSB   = 72;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    EMIT = 2'd2
  } state_t;

  // Inbound tuples carry the inner host address and the port offset, which is the conn id
  function automatic logic [TUPLE_W-1:0] pack_tuple(
    input logic        dir,
    input logic [31:0] src_ip,
    input logic [31:0] dst_ip,
    input logic [15:0] src_port,
    input logic [15:0] dst_port,
    input logic [7:0]  proto,
    input logic [31:0] lan_ip,
    input logic [15:0] port_base
  );
    logic [TUPLE_W-1:0] t;
    t = '0;
    t[IPB_LSB   +: 32] = src_ip;
    t[IPA_LSB   +: 32] = dir ? lan_ip : dst_ip;
    t[PORTB_LSB +: 16] = src_port;
    t[PORTA_LSB +: 16] = dir ? (dst_port - port_base) : dst_port;
    t[PROTO_LSB +: 8]  = proto;
    return t;
  endfunction

endpackage

// File: rtl/nat_tuple_client.sv
// Requesting side of the NAT hash lookup: packs one header into a tuple, waits for
// the connection index (or a timeout) and emits the translated header.
module nat_tuple_client
  import nat_pkg::*;
#(
  parameter bit          DIR       = 1'b0,
  parameter int          HASH_LEN  = 6,
  parameter logic [31:0] PUBLIC_IP = 32'hC0A80001,
  parameter logic [31:0] LAN_IP    = 32'h0A000002,
  parameter logic [15:0] PORT_BASE = 16'd40000,
  parameter logic [15:0] TIMEOUT   = 16'd256
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         hdr_valid,
  output logic         hdr_ready,
  input  logic [31:0]  hdr_src_ip,
  input  logic [31:0]  hdr_dst_ip,
  input  logic [15:0]  hdr_src_port,
  input  logic [15:0]  hdr_dst_port,
  input  logic [7:0]   hdr_proto,
  output logic [127:0] tuple_data,
  output logic         tuple_valid,
  input  logic [15:0]  conn_data,
  input  logic         conn_valid,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_src_ip,
  output logic [31:0]  out_dst_ip,
  output logic [15:0]  out_src_port,
  output logic [15:0]  out_dst_port,
  output logic [7:0]   out_proto,
  output logic         out_err,
  output logic [15:0]  timeout_cnt,
  output logic [15:0]  stray_cnt
);

  localparam logic [15:0] CONN_MASK = 16'((32'd1 << HASH_LEN) - 32'd1);

  state_t      state;
  logic [15:0] wait_cnt;
  logic [31:0] h_src_ip;
  logic [31:0] h_dst_ip;
  logic [15:0] h_src_port;
  logic [15:0] h_dst_port;
  logic [7:0]  h_proto;
  logic [15:0] port_off;
  logic        port_oor;
  logic        req_q;

  assign req_q       = (state == REQ);
  assign hdr_ready   = (state == IDLE);
  assign out_valid   = (state == EMIT);
  // Gated so the hash block never sees a second request right after answering
  assign tuple_valid = req_q & ~conn_valid;

  assign port_off = hdr_dst_port - PORT_BASE;
  assign port_oor = (hdr_dst_port < PORT_BASE) || ((port_off & ~CONN_MASK) != 16'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      h_src_ip     <= '0;
      h_dst_ip     <= '0;
      h_src_port   <= '0;
      h_dst_port   <= '0;
      h_proto      <= '0;
      tuple_data   <= '0;
      out_src_ip   <= '0;
      out_dst_ip   <= '0;
      out_src_port <= '0;
      out_dst_port <= '0;
      out_proto    <= '0;
      out_err      <= 1'b0;
      timeout_cnt  <= '0;
      stray_cnt    <= '0;
    end else begin
      if (conn_valid && !req_q && stray_cnt != 16'hFFFF)
        stray_cnt <= stray_cnt + 16'd1;

      case (state)
        IDLE: begin
          if (hdr_valid) begin
            h_src_ip   <= hdr_src_ip;
            h_dst_ip   <= hdr_dst_ip;
            h_src_port <= hdr_src_port;
            h_dst_port <= hdr_dst_port;
            h_proto    <= hdr_proto;
            tuple_data <= pack_tuple(DIR, hdr_src_ip, hdr_dst_ip, hdr_src_port,
                                     hdr_dst_port, hdr_proto, LAN_IP, PORT_BASE);
            wait_cnt   <= TIMEOUT;
            // Inbound ports outside the public range are rejected without a lookup
            if (DIR && port_oor) begin
              state        <= EMIT;
              out_src_ip   <= hdr_src_ip;
              out_dst_ip   <= hdr_dst_ip;
              out_src_port <= hdr_src_port;
              out_dst_port <= hdr_dst_port;
              out_proto    <= hdr_proto;
              out_err      <= 1'b1;
            end else begin
              state <= REQ;
            end
          end
        end

        REQ: begin
          if (conn_valid) begin
            state     <= EMIT;
            out_err   <= 1'b0;
            out_proto <= h_proto;
            if (DIR) begin
              out_src_ip   <= h_src_ip;
              out_src_port <= h_src_port;
              out_dst_ip   <= LAN_IP;
              out_dst_port <= conn_data;
            end else begin
              out_src_ip   <= PUBLIC_IP;
              out_src_port <= PORT_BASE + (conn_data & CONN_MASK);
              out_dst_ip   <= h_dst_ip;
              out_dst_port <= h_dst_port;
            end
          end else if (wait_cnt <= 16'd1) begin
            state        <= EMIT;
            out_err      <= 1'b1;
            out_src_ip   <= h_src_ip;
            out_dst_ip   <= h_dst_ip;
            out_src_port <= h_src_port;
            out_dst_port <= h_dst_port;
            out_proto    <= h_proto;
            if (timeout_cnt != 16'hFFFF)
              timeout_cnt <= timeout_cnt + 16'd1;
          end else begin
            wait_cnt <= wait_cnt - 16'd1;
          end
        end

        EMIT: begin
          if (out_ready)
            state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nat_tuple_client.sv
// Scoreboard bench for nat_tuple_client: one outbound and one inbound instance,
// directed scenarios followed by a randomized stream against a reference model.
module tb_nat_tuple_client;

  localparam int          TIMEOUT   = 256;
  localparam int          PORT_BASE = 40000;
  localparam int          HASH_LEN  = 6;
  localparam logic [31:0] PUBLIC_IP = 32'hC0A80001;
  localparam logic [31:0] LAN_IP    = 32'h0A000002;

  typedef struct packed {
    logic [31:0] sip;
    logic [31:0] dip;
    logic [15:0] sp;
    logic [15:0] dp;
    logic [7:0]  pr;
    logic        err;
  } out_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  logic         hdr_valid    [2];
  logic         hdr_ready    [2];
  logic [31:0]  hdr_src_ip   [2];
  logic [31:0]  hdr_dst_ip   [2];
  logic [15:0]  hdr_src_port [2];
  logic [15:0]  hdr_dst_port [2];
  logic [7:0]   hdr_proto    [2];
  logic [127:0] tuple_data   [2];
  logic         tuple_valid  [2];
  logic [15:0]  conn_data    [2];
  logic         conn_valid   [2];
  logic         out_valid    [2];
  logic         out_ready    [2];
  logic [31:0]  out_src_ip   [2];
  logic [31:0]  out_dst_ip   [2];
  logic [15:0]  out_src_port [2];
  logic [15:0]  out_dst_port [2];
  logic [7:0]   out_proto    [2];
  logic         out_err      [2];
  logic [15:0]  timeout_cnt  [2];
  logic [15:0]  stray_cnt    [2];

  int           total = 0;
  int           bad   = 0;
  out_t         exp_out   [2][$];
  logic [127:0] exp_tuple [2][$];
  logic [15:0]  exp_timeout [2];
  logic [15:0]  exp_stray   [2];

  always #5 clk = ~clk;

  nat_tuple_client #(.DIR(1'b0)) u_out (
    .clk(clk), .rst_n(rst_n),
    .hdr_valid(hdr_valid[0]), .hdr_ready(hdr_ready[0]),
    .hdr_src_ip(hdr_src_ip[0]), .hdr_dst_ip(hdr_dst_ip[0]),
    .hdr_src_port(hdr_src_port[0]), .hdr_dst_port(hdr_dst_port[0]), .hdr_proto(hdr_proto[0]),
    .tuple_data(tuple_data[0]), .tuple_valid(tuple_valid[0]),
    .conn_data(conn_data[0]), .conn_valid(conn_valid[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_src_ip(out_src_ip[0]), .out_dst_ip(out_dst_ip[0]),
    .out_src_port(out_src_port[0]), .out_dst_port(out_dst_port[0]), .out_proto(out_proto[0]),
    .out_err(out_err[0]), .timeout_cnt(timeout_cnt[0]), .stray_cnt(stray_cnt[0])
  );

  nat_tuple_client #(.DIR(1'b1)) u_in (
    .clk(clk), .rst_n(rst_n),
    .hdr_valid(hdr_valid[1]), .hdr_ready(hdr_ready[1]),
    .hdr_src_ip(hdr_src_ip[1]), .hdr_dst_ip(hdr_dst_ip[1]),
    .hdr_src_port(hdr_src_port[1]), .hdr_dst_port(hdr_dst_port[1]), .hdr_proto(hdr_proto[1]),
    .tuple_data(tuple_data[1]), .tuple_valid(tuple_valid[1]),
    .conn_data(conn_data[1]), .conn_valid(conn_valid[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_src_ip(out_src_ip[1]), .out_dst_ip(out_dst_ip[1]),
    .out_src_port(out_src_port[1]), .out_dst_port(out_dst_port[1]), .out_proto(out_proto[1]),
    .out_err(out_err[1]), .timeout_cnt(timeout_cnt[1]), .stray_cnt(stray_cnt[1])
  );

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitors: pop the scoreboard whenever a tuple request starts or an output is presented
  for (genvar g = 0; g < 2; g++) begin : g_mon
    logic tv_prev;
    out_t act;
    initial begin
      tv_prev = 1'b0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          tv_prev = 1'b0;
        end else begin
          if (tuple_valid[g] && !tv_prev) begin
            if (exp_tuple[g].size() == 0)
              checkOutput("unexpected_tuple", 128'(tuple_valid[g]), 128'(0));
            else
              checkOutput("tuple", tuple_data[g], exp_tuple[g].pop_front());
          end
          tv_prev = tuple_valid[g];
          if (out_valid[g]) begin
            act = {out_src_ip[g], out_dst_ip[g], out_src_port[g], out_dst_port[g],
                   out_proto[g], out_err[g]};
            checkOutput("hdr_ready_busy", 128'(hdr_ready[g]), 128'(0));
            if (exp_out[g].size() == 0)
              checkOutput("unexpected_out", 128'(out_valid[g]), 128'(0));
            else if (out_ready[g])
              checkOutput("out_handshake", 128'(act), 128'(exp_out[g].pop_front()));
            else
              checkOutput("out_hold", 128'(act), 128'(exp_out[g][0]));
          end
        end
      end
    end
  end

  task automatic resetChecks(input int d);
    checkOutput("rst_hdr_ready", 128'(hdr_ready[d]), 128'(1));
    checkOutput("rst_tuple_valid", 128'(tuple_valid[d]), 128'(0));
    checkOutput("rst_tuple_data", tuple_data[d], 128'(0));
    checkOutput("rst_out_valid", 128'(out_valid[d]), 128'(0));
    checkOutput("rst_out_fields", 128'({out_src_ip[d], out_dst_ip[d], out_src_port[d],
                out_dst_port[d], out_proto[d], out_err[d]}), 128'(0));
    checkOutput("rst_timeout_cnt", 128'(timeout_cnt[d]), 128'(0));
    checkOutput("rst_stray_cnt", 128'(stray_cnt[d]), 128'(0));
    exp_timeout[d] = '0;
    exp_stray[d]   = '0;
  endtask

  // delay: REQ cycle (1 = first) in which conn_valid is driven; beyond TIMEOUT it lands late
  task automatic applyStimulus(input int d, input logic [31:0] sip, input logic [31:0] dip,
                               input logic [15:0] sp, input logic [15:0] dp, input logic [7:0] pr,
                               input int delay, input logic [15:0] conn, input int hold,
                               input bit pre_stray);
    out_t         e;
    logic [127:0] et;
    bit           oor;
    bit           tmo;
    int           n;
    oor = (d == 1) && ((int'(dp) < PORT_BASE) || (int'(dp) - PORT_BASE >= (1 << HASH_LEN)));
    tmo = !oor && (delay > TIMEOUT);
    et  = {24'h0, sip, (d == 1) ? LAN_IP : dip, sp,
           (d == 1) ? 16'(int'(dp) - PORT_BASE) : dp, pr};
    e   = '{sip: sip, dip: dip, sp: sp, dp: dp, pr: pr, err: 1'b0};
    if (oor || tmo) begin
      e.err = 1'b1;
    end else if (d == 0) begin
      e.sip = PUBLIC_IP;
      e.sp  = 16'((PORT_BASE + int'(conn) % (1 << HASH_LEN)) % 65536);
    end else begin
      e.dip = LAN_IP;
      e.dp  = conn;
    end
    exp_out[d].push_back(e);
    if (!oor && delay > 1) exp_tuple[d].push_back(et);
    if (tmo) exp_timeout[d] = exp_timeout[d] + 16'd1;

    if (pre_stray) begin
      conn_valid[d] = 1'b1;
      conn_data[d]  = 16'($urandom);
      @(posedge clk); #1;
      conn_valid[d] = 1'b0;
      exp_stray[d]  = exp_stray[d] + 16'd1;
    end

    n = 0;
    while (!hdr_ready[d] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("hdr_ready_idle", 128'(hdr_ready[d]), 128'(1));

    hdr_src_ip[d] = sip; hdr_dst_ip[d] = dip; hdr_src_port[d] = sp;
    hdr_dst_port[d] = dp; hdr_proto[d] = pr; hdr_valid[d] = 1'b1;
    @(posedge clk); #1;
    hdr_valid[d] = 1'b0;
    hdr_src_ip[d] = $urandom; hdr_dst_ip[d] = $urandom; hdr_src_port[d] = 16'($urandom);
    hdr_dst_port[d] = 16'($urandom); hdr_proto[d] = 8'($urandom);

    if (oor) begin
      checkOutput("oor_out_valid", 128'(out_valid[d]), 128'(1));
      checkOutput("oor_tuple_valid", 128'(tuple_valid[d]), 128'(0));
    end else begin
      checkOutput("req_tuple_valid", 128'(tuple_valid[d]), 128'(1));
      n = 1;
      while (n < delay) begin
        if (tmo && n == TIMEOUT)     checkOutput("tmo_not_yet", 128'(out_valid[d]), 128'(0));
        if (tmo && n == TIMEOUT + 1) checkOutput("tmo_latency", 128'(out_valid[d]), 128'(1));
        @(posedge clk); #1;
        n++;
      end
      if (!tmo) checkOutput("out_early", 128'(out_valid[d]), 128'(0));
      conn_valid[d] = 1'b1;
      conn_data[d]  = conn;
      #1;
      checkOutput("tuple_valid_gated", 128'(tuple_valid[d]), 128'(0));
      checkOutput("tuple_at_conn", tuple_data[d], et);
      @(posedge clk); #1;
      conn_valid[d] = 1'b0;
      conn_data[d]  = 16'($urandom);
      if (tmo) exp_stray[d] = exp_stray[d] + 16'd1;
      checkOutput("out_after_conn", 128'(out_valid[d]), 128'(1));
    end

    repeat (hold) begin
      @(posedge clk); #1;
    end
    out_ready[d] = 1'b1;
    @(posedge clk); #1;
    out_ready[d] = 1'b0;
    checkOutput("out_released", 128'(out_valid[d]), 128'(0));
    checkOutput("hdr_ready_after", 128'(hdr_ready[d]), 128'(1));
    checkOutput("timeout_cnt", 128'(timeout_cnt[d]), 128'(exp_timeout[d]));
    checkOutput("stray_cnt", 128'(stray_cnt[d]), 128'(exp_stray[d]));
  endtask

  task automatic resetMidRequest(input int d);
    hdr_src_ip[d] = 32'h0A000002; hdr_dst_ip[d] = 32'h01020304; hdr_src_port[d] = 16'd5555;
    hdr_dst_port[d] = (d == 1) ? 16'd40010 : 16'd80; hdr_proto[d] = 8'd6;
    exp_tuple[d].push_back({24'h0, 32'h0A000002, (d == 1) ? LAN_IP : 32'h01020304, 16'd5555,
                            (d == 1) ? 16'd10 : 16'd80, 8'd6});
    hdr_valid[d] = 1'b1;
    @(posedge clk); #1;
    hdr_valid[d] = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    resetChecks(0);
    resetChecks(1);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int d;
    int dl;
    logic [15:0] dp;
    for (int i = 0; i < 2; i++) begin
      hdr_valid[i] = 1'b0; hdr_src_ip[i] = '0; hdr_dst_ip[i] = '0; hdr_src_port[i] = '0;
      hdr_dst_port[i] = '0; hdr_proto[i] = '0; conn_data[i] = '0; conn_valid[i] = 1'b0;
      out_ready[i] = 1'b0; exp_timeout[i] = '0; exp_stray[i] = '0;
    end
    #2 rst_n = 1'b0;
    #1;
    resetChecks(0);
    resetChecks(1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    $display("[TB] outbound basic translation");
    applyStimulus(0, 32'h0A000002, 32'h08080808, 16'd1234, 16'd53, 8'd17, 5, 16'd3, 0, 1'b0);
    $display("[TB] response in first request cycle");
    applyStimulus(0, 32'h0A000002, 32'h08080808, 16'd999, 16'd443, 8'd6, 1, 16'd63, 1, 1'b0);
    $display("[TB] timeout, then late response");
    applyStimulus(0, 32'h0A000002, 32'h01010101, 16'd4321, 16'd80, 8'd6, 260, 16'd7, 0, 1'b0);
    $display("[TB] response on the expiry cycle");
    applyStimulus(0, 32'h0A000003, 32'h01010101, 16'd4321, 16'd80, 8'd6, TIMEOUT, 16'd70, 0, 1'b0);
    $display("[TB] inbound translation and port range");
    applyStimulus(1, 32'h08080808, 32'hC0A80001, 16'd53, 16'd40007, 8'd17, 3, 16'd1234, 0, 1'b0);
    applyStimulus(1, 32'h08080808, 32'hC0A80001, 16'd53, 16'd39999, 8'd17, 3, 16'd1, 0, 1'b0);
    applyStimulus(1, 32'h08080808, 32'hC0A80001, 16'd53, 16'd40064, 8'd17, 3, 16'd1, 2, 1'b0);
    applyStimulus(1, 32'h08080808, 32'hC0A80001, 16'd53, 16'd40063, 8'd17, 2, 16'd777, 0, 1'b1);
    $display("[TB] downstream backpressure");
    applyStimulus(0, 32'h0A000005, 32'h09090909, 16'd1000, 16'd22, 8'd6, 4, 16'd12, 10, 1'b1);
    applyStimulus(0, 32'h0A000006, 32'h09090909, 16'd1001, 16'd22, 8'd6, 2, 16'd13, 0, 1'b0);
    $display("[TB] reset during request");
    resetMidRequest(0);
    applyStimulus(0, 32'h0A000002, 32'h08080808, 16'd1234, 16'd53, 8'd17, 5, 16'd3, 0, 1'b0);

    $display("[TB] randomized stream");
    for (int i = 0; i < 40; i++) begin
      d  = int'($urandom_range(0, 1));
      dl = ($urandom_range(0, 19) == 0) ? 300 : int'($urandom_range(1, 12));
      if (d == 1 && $urandom_range(0, 3) == 0) dp = 16'($urandom);
      else if (d == 1) dp = 16'(PORT_BASE + int'($urandom_range(0, 63)));
      else dp = 16'($urandom);
      applyStimulus(d, $urandom, $urandom, 16'($urandom), dp, 8'($urandom), dl,
                    16'($urandom), int'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0));
    end

    repeat (5) @(posedge clk);
    checkOutput("scoreboard_drained", 128'(exp_out[0].size() + exp_out[1].size() +
                exp_tuple[0].size() + exp_tuple[1].size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
